// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: opcode/funct constants, phase-bus
// indices, sequencer state and instruction-class encodings.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // Bit positions on the one-hot phase bus p[4:0]
  localparam int unsigned PH_P0 = 0;
  localparam int unsigned PH_P1 = 1;
  localparam int unsigned PH_P2 = 2;
  localparam int unsigned PH_P3 = 3;
  localparam int unsigned PH_P4 = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_P3,
    ST_P4,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    CL_ADD,
    CL_LW,
    CL_SW,
    CL_ILL
  } iclass_e;

endpackage

// File: rtl/op_classify.sv
// Combinational instruction classifier.
//   op_i     : IR[31:26]
//   irfunc_i : IR[5:0]
//   cls_o    : instruction class (CL_ILL for anything unsupported)
module op_classify
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] irfunc_i,
  output iclass_e    cls_o
);

  always_comb begin
    cls_o = CL_ILL;
    unique case (op_i)
      OP_RTYPE: cls_o = (irfunc_i == FUNCT_ADD) ? CL_ADD : CL_ILL;
      OP_LW:    cls_o = CL_LW;
      OP_SW:    cls_o = CL_SW;
      default:  cls_o = CL_ILL;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// Multi-cycle phase sequencer for the control unit.
// Steps each instruction through P0 fetch, P1 decode, P2 execute,
// P3 memory, P4 writeback (skipping P3/P4 by class), waits on mem_ready,
// issues the architectural write strobes and counts retired instructions.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   run               : start/continue issuing (sampled in IDLE and at retire)
//   op, irfunc        : IR opcode and funct fields
//   mem_ready         : memory access complete this cycle (P0/P3 only)
//   p                 : registered one-hot phase, 0 in IDLE/HALT
//   pc_write/ir_write : fetch-complete strobes
//   mem_read/mem_write: memory request levels
//   reg_write         : register-file write strobe in P4
//   illegal, timeout  : sticky fault flags (sequencer halts)
//   retired           : retired-instruction count, wraps
module phase_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       op,
  input  logic [5:0]       irfunc,
  input  logic             mem_ready,
  output logic [4:0]       p,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  iclass_e           cls_q, cls_d, cls_dec;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [4:0]        p_q, p_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              retire;

  op_classify u_op_classify (
    .op_i     (op),
    .irfunc_i (irfunc),
    .cls_o    (cls_dec)
  );

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_P0;
      end
      ST_P0: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_P1;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_P1: begin
        cls_d = cls_dec;
        if (cls_dec == CL_ILL) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          state_d = ST_P2;
        end
      end
      ST_P2: begin
        state_d = (cls_q == CL_ADD) ? ST_P4 : ST_P3;
      end
      ST_P3: begin
        mem_read  = (cls_q == CL_LW);
        mem_write = (cls_q == CL_SW);
        if (mem_ready) begin
          if (cls_q == CL_LW) state_d = ST_P4;
          else                retire  = 1'b1;
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_P4: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase

    if (retire) state_d = run ? ST_P0 : ST_IDLE;

    // Any state change is a phase entry; the only self-loops are the
    // P0/P3 wait loops, which must keep counting.
    if (state_d != state_q) wait_d = '0;

    retired_d = retired_q + CNT_W'(retire);

    p_d = '0;
    unique case (state_d)
      ST_P0:   p_d[PH_P0] = 1'b1;
      ST_P1:   p_d[PH_P1] = 1'b1;
      ST_P2:   p_d[PH_P2] = 1'b1;
      ST_P3:   p_d[PH_P3] = 1'b1;
      ST_P4:   p_d[PH_P4] = 1'b1;
      default: p_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cls_q     <= CL_ADD;
      wait_q    <= '0;
      retired_q <= '0;
      p_q       <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      p_q       <= p_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign p       = p_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
`timescale 1ns/1ps
module tb_phase_sequencer;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_FADD  = 6'b100000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BAD   = 6'b000010;

  // strobe vector order: {pc_write, ir_write, mem_read, mem_write, reg_write}
  localparam logic [4:0] S_NONE  = 5'b00000;
  localparam logic [4:0] S_FETCH = 5'b11100;
  localparam logic [4:0] S_RD    = 5'b00100;
  localparam logic [4:0] S_WR    = 5'b00010;
  localparam logic [4:0] S_RW    = 5'b00001;

  localparam logic [4:0] PX = 5'b00000;
  localparam logic [4:0] Q0 = 5'b00001;
  localparam logic [4:0] Q1 = 5'b00010;
  localparam logic [4:0] Q2 = 5'b00100;
  localparam logic [4:0] Q3 = 5'b01000;
  localparam logic [4:0] Q4 = 5'b10000;

  typedef struct packed {
    logic [4:0]  p;
    logic [4:0]  s;
    logic        ill;
    logic        to;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [5:0]  op;
  logic [5:0]  irfunc;
  logic        mem_ready;
  logic [4:0]  p;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write;
  logic        illegal, timeout;
  logic [31:0] retired;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  phase_sequencer #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .op        (op),
    .irfunc    (irfunc),
    .mem_ready (mem_ready),
    .p         (p),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .illegal   (illegal),
    .timeout   (timeout),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the DUT
  // must show during that cycle.
  task automatic cyc(input logic rst, input logic r, input logic [5:0] o, input logic [5:0] f,
                     input logic mr, input logic [4:0] ep, input logic [4:0] es,
                     input logic eill, input logic eto, input logic [31:0] eret);
    exp_t e;
    @(negedge clk);
    rst_n = rst; run = r; op = o; irfunc = f; mem_ready = mr;
    e.p = ep; e.s = es; e.ill = eill; e.to = eto; e.ret = eret;
    exp_q.push_back(e);
  endtask

  // Monitor: compares just after each falling edge, far from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("phase", {27'd0, p}, {27'd0, e.p});
        check("strobes", {27'd0, pc_write, ir_write, mem_read, mem_write, reg_write}, {27'd0, e.s});
        check("flags", {30'd0, illegal, timeout}, {30'd0, e.ill, e.to});
        check("retired", retired, e.ret);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned guard;
    rst_n = 1'b0; run = 1'b0; op = '0; irfunc = '0; mem_ready = 1'b0;

    // reset state
    cyc(0, 0, T_RTYPE, T_FADD, 0, PX, S_NONE, 0, 0, 0);
    cyc(0, 1, T_RTYPE, T_FADD, 1, PX, S_NONE, 0, 0, 0);

    // ADD, mem_ready tied high (also ignored in P1/P2)
    cyc(1, 1, T_RTYPE, T_FADD, 1, PX, S_NONE,  0, 0, 0);
    cyc(1, 1, T_RTYPE, T_FADD, 1, Q0, S_FETCH, 0, 0, 0);
    cyc(1, 1, T_RTYPE, T_FADD, 1, Q1, S_NONE,  0, 0, 0);
    cyc(1, 1, T_RTYPE, T_FADD, 1, Q2, S_NONE,  0, 0, 0);
    cyc(1, 1, T_RTYPE, T_FADD, 1, Q4, S_RW,    0, 0, 0);

    // LW with three wait cycles in P3
    cyc(1, 1, T_LW, 6'd0, 1, Q0, S_FETCH, 0, 0, 1);
    cyc(1, 1, T_LW, 6'd0, 1, Q1, S_NONE,  0, 0, 1);
    cyc(1, 1, T_LW, 6'd0, 1, Q2, S_NONE,  0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 1, T_LW, 6'd0, 0, Q3, S_RD, 0, 0, 1);
    cyc(1, 1, T_LW, 6'd0, 1, Q3, S_RD,    0, 0, 1);
    cyc(1, 1, T_LW, 6'd0, 1, Q4, S_RW,    0, 0, 1);

    // SW zero-wait
    cyc(1, 1, T_SW, 6'd7, 1, Q0, S_FETCH, 0, 0, 2);
    cyc(1, 1, T_SW, 6'd7, 1, Q1, S_NONE,  0, 0, 2);
    cyc(1, 1, T_SW, 6'd7, 1, Q2, S_NONE,  0, 0, 2);
    cyc(1, 1, T_SW, 6'd7, 1, Q3, S_WR,    0, 0, 2);

    // LW with run dropped in P2: completes, then IDLE
    cyc(1, 1, T_LW, 6'd0, 1, Q0, S_FETCH, 0, 0, 3);
    cyc(1, 1, T_LW, 6'd0, 1, Q1, S_NONE,  0, 0, 3);
    cyc(1, 0, T_LW, 6'd0, 1, Q2, S_NONE,  0, 0, 3);
    cyc(1, 0, T_LW, 6'd0, 1, Q3, S_RD,    0, 0, 3);
    cyc(1, 0, T_LW, 6'd0, 1, Q4, S_RW,    0, 0, 3);
    cyc(1, 0, T_LW, 6'd0, 1, PX, S_NONE,  0, 0, 4);
    cyc(1, 0, T_LW, 6'd0, 1, PX, S_NONE,  0, 0, 4);

    // LW interrupted by asynchronous reset in P3
    cyc(1, 1, T_LW, 6'd0, 1, PX, S_NONE,  0, 0, 4);
    cyc(1, 1, T_LW, 6'd0, 1, Q0, S_FETCH, 0, 0, 4);
    cyc(1, 1, T_LW, 6'd0, 0, Q1, S_NONE,  0, 0, 4);
    cyc(1, 1, T_LW, 6'd0, 0, Q2, S_NONE,  0, 0, 4);
    cyc(1, 1, T_LW, 6'd0, 0, Q3, S_RD,    0, 0, 4);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_p", {27'd0, p}, 32'd0);
    check("async_rst_rd", {31'd0, mem_read}, 32'd0);
    check("async_rst_ret", retired, 32'd0);
    cyc(1, 0, T_LW, 6'd0, 0, PX, S_NONE,  0, 0, 0);

    // illegal opcode: halt, absorbing
    cyc(1, 1, T_BAD, 6'd0, 1, PX, S_NONE,  0, 0, 0);
    cyc(1, 1, T_BAD, 6'd0, 1, Q0, S_FETCH, 0, 0, 0);
    cyc(1, 1, T_BAD, 6'd0, 1, Q1, S_NONE,  0, 0, 0);
    for (int i = 0; i < 22; i++)
      cyc(1, 1'($urandom), T_BAD, 6'd0, 1'($urandom), PX, S_NONE, 1, 0, 0);
    cyc(0, 0, T_BAD, 6'd0, 0, PX, S_NONE, 0, 0, 0);

    // fetch timeout: 16 wait cycles in P0, then halt
    cyc(1, 1, T_RTYPE, T_FADD, 0, PX, S_NONE, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, T_RTYPE, T_FADD, 0, Q0, S_RD, 0, 0, 0);
    for (int i = 0; i < 5; i++)  cyc(1, 1, T_RTYPE, T_FADD, 1'($urandom), PX, S_NONE, 0, 1, 0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) check("drain", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
